// File: rtl/fir_pkg.sv
// Shared constants, coefficient set, FSM state type and circular-buffer address helper
// for the folded symmetric FIR engine.
// Coefficients are symmetric: entry k equals entry ORDER-1-k.
package fir_pkg;

  localparam int WIDTH = 16;
  localparam int ORDER = 31;
  localparam int N     = (ORDER - 1) / 2;
  localparam int ACC_W = 2 * WIDTH + $clog2(ORDER) + 1;

  typedef logic [WIDTH-1:0] coeff_arr_t [ORDER];

  localparam coeff_arr_t FIR_COEFFS = '{
    16'h0003, 16'hFFF0, 16'h0025, 16'h0102, 16'h0A11, 16'h1234, 16'h0007, 16'h8001,
    16'h00FF, 16'h3C3C, 16'h0040, 16'h7FFF, 16'h0500, 16'h2222, 16'hABCD, 16'h4000,
    16'hABCD, 16'h2222, 16'h0500, 16'h7FFF, 16'h0040, 16'h3C3C, 16'h00FF, 16'h8001,
    16'h0007, 16'h1234, 16'h0A11, 16'h0102, 16'h0025, 16'hFFF0, 16'h0003
  };

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  // Buffer index of x[k] given the index of the newest sample. Both inputs are
  // in 0..order-1, so one conditional add replaces a general modulo.
  function automatic int tap_addr(input int newest, input int k, input int order = ORDER);
    int a;
    a = newest - k;
    if (a < 0) a = a + order;
    return a;
  endfunction

endpackage

// File: rtl/fir_fold_mac.sv
// Pre-add / multiply / accumulate datapath: acc += coeff * (a + (use_b ? b : 0)).
// One cycle per term; acc_nxt exposes the value being written this cycle.
// clr has priority over en; no handshake, the controller sequences it.
module fir_fold_mac #(
  parameter int WIDTH = 16,
  parameter int ACC_W = 38
) (
  input  logic             clk,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] coeff,
  input  logic             use_b,
  input  logic             clr,
  input  logic             en,
  output logic [ACC_W-1:0] acc,
  output logic [ACC_W-1:0] acc_nxt
);

  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [WIDTH:0]     pre;
  logic [2*WIDTH:0]   prod;

  // Full-width pre-add (carry kept) and product, then clear/accumulate select.
  always_comb begin
    pre   = {1'b0, a} + (use_b ? {1'b0, b} : '0);
    prod  = {{WIDTH{1'b0}}, pre} * {{(WIDTH+1){1'b0}}, coeff};
    acc_d = acc_q;
    if (clr)     acc_d = '0;
    else if (en) acc_d = acc_q + {{(ACC_W-2*WIDTH-1){1'b0}}, prod};
  end

  // Accumulator register; reset is applied by the controller through clr.
  always_ff @(posedge clk) begin
    acc_q <= acc_d;
  end

  assign acc     = acc_q;
  assign acc_nxt = acc_d;

endmodule

// File: rtl/fir_fold_ctrl.sv
// Folded symmetric FIR: one pre-add/MAC per coefficient pair, sequenced IDLE -> MAC -> OUT.
// Latency: output valid N+2 cycles after the accepting cycle; sample period N+3 minimum.
// in_ready only in IDLE; OUT holds out_y/out_valid until out_ready, no in/out overlap.
module fir_fold_ctrl
  import fir_pkg::*;
#(
  parameter int               WIDTH = fir_pkg::WIDTH,
  parameter int               ORDER = fir_pkg::ORDER,
  parameter logic [WIDTH-1:0] COEFFS [ORDER] = fir_pkg::FIR_COEFFS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_sample,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             busy
);

  localparam int N     = (ORDER - 1) / 2;
  localparam int ACC_W = 2 * WIDTH + $clog2(ORDER) + 1;
  localparam int PTR_W = $clog2(ORDER);

  state_t           state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] newest_q, newest_d;
  logic [PTR_W-1:0] j_q, j_d;
  logic [WIDTH-1:0] out_y_q, out_y_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] smp_q [ORDER];
  logic [WIDTH-1:0] smp_d [ORDER];

  logic [PTR_W-1:0] addr_a, addr_b;
  logic             mac_clr, mac_en, mac_use_b;
  logic [WIDTH-1:0] mac_coeff;
  logic [ACC_W-1:0] acc, acc_nxt;

  assign in_ready  = (state_q == IDLE) && !reset;
  assign out_valid = out_valid_q;
  assign out_y     = out_y_q;
  assign busy      = (state_q != IDLE);

  // Next-state, buffer write and MAC control. j pairs x[j] with x[ORDER-1-j];
  // the centre tap (j == N) has no partner and closes the sum.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    newest_d    = newest_q;
    j_d         = j_q;
    out_y_d     = out_y_q;
    out_valid_d = out_valid_q;
    smp_d       = smp_q;
    mac_clr     = reset;
    mac_en      = 1'b0;
    mac_use_b   = 1'b0;
    addr_a      = PTR_W'(tap_addr(int'(newest_q), int'(j_q), ORDER));
    addr_b      = PTR_W'(tap_addr(int'(newest_q), ORDER - 1 - int'(j_q), ORDER));
    mac_coeff   = COEFFS[j_q];
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          smp_d[wr_ptr_q] = in_sample;
          newest_d        = wr_ptr_q;
          wr_ptr_d        = (wr_ptr_q == PTR_W'(ORDER - 1)) ? '0 : wr_ptr_q + 1'b1;
          j_d             = '0;
          mac_clr         = 1'b1;
          state_d         = MAC;
        end
      end
      MAC: begin
        mac_en = 1'b1;
        if (j_q == PTR_W'(N)) begin
          out_y_d     = acc_nxt[WIDTH-1:0];
          out_valid_d = 1'b1;
          state_d     = OUT;
        end else begin
          mac_use_b = 1'b1;
          j_d       = j_q + 1'b1;
        end
      end
      OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset clears the history so early outputs see zeros.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      newest_q    <= '0;
      j_q         <= '0;
      out_y_q     <= '0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < ORDER; i++) smp_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      newest_q    <= newest_d;
      j_q         <= j_d;
      out_y_q     <= out_y_d;
      out_valid_q <= out_valid_d;
      smp_q       <= smp_d;
    end
  end

  fir_fold_mac #(
    .WIDTH(WIDTH),
    .ACC_W(ACC_W)
  ) u_mac (
    .clk    (clk),
    .a      (smp_q[addr_a]),
    .b      (smp_q[addr_b]),
    .coeff  (mac_coeff),
    .use_b  (mac_use_b),
    .clr    (mac_clr),
    .en     (mac_en),
    .acc    (acc),
    .acc_nxt(acc_nxt)
  );

endmodule

// File: tb/tb_fir_fold_ctrl.sv
// Bench for fir_fold_ctrl: directed vector table (impulse, step) plus hand-written
// sequences for latency, period, backpressure, reset mid-MAC and a random run
// scored against a direct-form (unfolded) FIR model.
module tb_fir_fold_ctrl;
  import fir_pkg::*;

  logic             clk = 1'b0;
  logic             reset, in_valid, in_ready, out_valid, out_ready, busy;
  logic [WIDTH-1:0] in_sample, out_y;

  always #5 clk = ~clk;

  fir_fold_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_sample(in_sample),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_y    (out_y),
    .busy     (busy)
  );

  int errors = 0;
  int checks = 0;
  int acc_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Direct-form reference: history with newest sample at index 0.
  logic [WIDTH-1:0] hist [ORDER];
  logic [WIDTH-1:0] expq [$];

  function automatic logic [WIDTH-1:0] model_y();
    logic [63:0] s;
    s = '0;
    for (int k = 0; k < ORDER; k++) s += 64'(FIR_COEFFS[k]) * 64'(hist[k]);
    return s[WIDTH-1:0];
  endfunction

  // Scoreboard, sampled on the falling edge while inputs and outputs are stable.
  always @(negedge clk) begin
    if (reset) begin
      for (int k = 0; k < ORDER; k++) hist[k] = '0;
      expq.delete();
    end else begin
      if (in_valid && in_ready) begin
        for (int k = ORDER - 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = in_sample;
        expq.push_back(model_y());
        acc_cnt++;
      end
      if (out_valid && out_ready) begin
        if (expq.size() == 0) chk("sb_unexpected_output", 64'(expq.size()), 64'd1);
        else chk("scoreboard", out_y, expq.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string nm);
    int n;
    n = 0;
    while (!in_ready && n < 200) begin step(); n++; end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL %s: in_ready timeout, got 0 expected 1", nm);
    end
  endtask

  task automatic wait_valid(input string nm);
    int n;
    n = 0;
    while (!out_valid && n < 200) begin step(); n++; end
    if (!out_valid) begin
      checks++; errors++;
      $display("FAIL %s: out_valid timeout, got 0 expected 1", nm);
    end
  endtask

  // One sample in, one result out, with out_ready held high.
  task automatic xfer(input logic [WIDTH-1:0] s, output logic [WIDTH-1:0] y);
    in_sample = s;
    in_valid  = 1'b1;
    wait_ready("xfer");
    step();
    in_valid = 1'b0;
    wait_valid("xfer");
    y = out_y;
    step();
  endtask

  typedef struct {
    logic [WIDTH-1:0] smp;
    logic [WIDTH-1:0] exp_y;
    string            nm;
  } vec_t;

  localparam int NVEC = ORDER + 40;
  vec_t vecs [NVEC];

  initial begin : main
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] run;
    int               n;
    bit               flag;
    int               acc0;

    // Impulse: outputs walk through every coefficient. Step: running sums
    // that saturate at the full coefficient sum once the history fills.
    run = '0;
    for (int i = 0; i < ORDER; i++) begin
      vecs[i].smp   = (i == 0) ? WIDTH'(1) : '0;
      vecs[i].exp_y = FIR_COEFFS[i];
      vecs[i].nm    = $sformatf("impulse%0d", i);
    end
    for (int i = 0; i < 40; i++) begin
      if (i < ORDER) run = run + FIR_COEFFS[i];
      vecs[ORDER+i].smp   = WIDTH'(1);
      vecs[ORDER+i].exp_y = run;
      vecs[ORDER+i].nm    = $sformatf("step%0d", i);
    end

    reset = 1'b1; in_valid = 1'b0; in_sample = '0; out_ready = 1'b1;
    step();
    chk("rst_in_ready", in_ready, 0);
    step(); step();
    reset = 1'b0;
    step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_y", out_y, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready_after", in_ready, 1);

    for (int i = 0; i < NVEC; i++) begin
      xfer(vecs[i].smp, y);
      chk(vecs[i].nm, y, vecs[i].exp_y);
      if (i == N) chk("impulse_centre", y, FIR_COEFFS[N]);
    end

    // Latency and in_ready low through MAC/OUT.
    in_sample = 16'h0042; in_valid = 1'b1;
    wait_ready("lat");
    step();
    in_valid = 1'b0;
    n = 1; flag = 1'b1;
    while (!out_valid && n < 100) begin
      if (in_ready || !busy) flag = 1'b0;
      step(); n++;
    end
    chk("lat_cycles", 64'(n), 64'(N + 2));
    chk("lat_rdy_low_mac", flag, 1);
    chk("lat_rdy_low_out", in_ready, 0);
    step();

    // Sample period with in_valid and out_ready held high.
    wait_ready("period");
    in_sample = '0; in_valid = 1'b1;
    step();
    n = 1;
    while (!in_ready && n < 100) begin step(); n++; end
    chk("period", 64'(n), 64'(N + 3));
    in_valid = 1'b0;

    // Backpressure: result held, held-high in_valid not consumed until release.
    out_ready = 1'b0;
    in_sample = 16'h0ABC; in_valid = 1'b1;
    wait_ready("bp");
    acc0 = acc_cnt;
    step();
    in_sample = 16'h1234;
    wait_valid("bp");
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", out_valid, 1);
      chk("bp_y", out_y, (expq.size() > 0) ? expq[0] : ~out_y);
      chk("bp_in_ready", in_ready, 0);
      step();
    end
    chk("bp_no_consume", 64'(acc_cnt - acc0), 64'd1);
    out_ready = 1'b1;
    step();
    chk("bp_accept_ready", in_ready, 1);
    step();
    chk("bp_busy_after_accept", busy, 1);
    chk("bp_consumed_once", 64'(acc_cnt - acc0), 64'd2);
    in_valid = 1'b0;
    wait_valid("bp2");
    step();

    // Reset at j=7 of a MAC pass: no output, history cleared.
    in_sample = 16'h0777; in_valid = 1'b1;
    wait_ready("rst_mac");
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 7; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrst_busy", busy, 0);
    flag = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) flag = 1'b1;
      step();
    end
    chk("midrst_no_output", flag, 0);
    xfer(WIDTH'(1), y);
    chk("midrst_impulse", y, FIR_COEFFS[0]);

    // Random samples, random backpressure; scoreboard checks every result.
    for (int i = 0; i < 200; i++) begin
      in_sample = WIDTH'($urandom);
      in_valid  = 1'b1;
      n = 0;
      while (!in_ready && n < 200) begin
        out_ready = 1'($urandom_range(0, 1));
        step(); n++;
      end
      if (!in_ready) begin
        checks++; errors++;
        $display("FAIL rand_accept: in_ready timeout, got 0 expected 1");
      end
      step();
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    n = 0;
    while ((expq.size() != 0 || busy) && n < 200) begin step(); n++; end
    chk("rand_drain", 64'(expq.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
